hamming_slicer: RTL and testbench

- Upstream feeder for the sequential Hamming-distance stage.
- Accepts a full N-bit pair (g_vec, e_vec) through a valid/ready handshake.
- Issues a one-cycle accumulator-clear pulse, then presents the pair as CC consecutive M-bit slices (M = N/CC), one per clock.
- Flags the final slice so the consumer knows its combinational sum output is complete on that cycle.
- Holds the slice outputs at zero while idle, so the downstream accumulator's sum is not disturbed.

---
 rtl/hamming_slicer_if.sv | 31 +++
 rtl/hamming_slicer.sv | 127 ++++++++++++
 tb/tb_hamming_slicer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hamming_slicer_if.sv
// Operand/slice bundle between the pair source, the slicer and the
// Hamming-distance consumer.
//   in_valid/in_ready/g_vec/e_vec : N-bit operand pair handshake
//   g_slice/e_slice               : M-bit slice pair presented per clock
//   slice_valid/acc_clr/last/busy : slice framing for the consumer
// Modports: slave = slicer side, master = source/consumer side.
interface hamming_slicer_if #(
  parameter int N = 8,
  parameter int M = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] g_vec;
  logic [N-1:0] e_vec;
  logic [M-1:0] g_slice;
  logic [M-1:0] e_slice;
  logic         slice_valid;
  logic         acc_clr;
  logic         last;
  logic         busy;

  modport slave (
    input  in_valid, g_vec, e_vec,
    output in_ready, g_slice, e_slice, slice_valid, acc_clr, last, busy
  );

  modport master (
    output in_valid, g_vec, e_vec,
    input  in_ready, g_slice, e_slice, slice_valid, acc_clr, last, busy
  );
endinterface

// File: rtl/hamming_slicer.sv
// Upstream feeder for the sequential Hamming-distance stage.
// Accepts an N-bit (g, e) pair, emits a one-cycle accumulator clear, then
// presents the pair as CC slices of M = N/CC bits, one per clock, flagging
// the final slice with last. Slices are held at zero when not live.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hamming_slicer_if.slave (handshake in, slices out)
// Optional feature: define HAMMING_SLICER_MSB_FIRST_EN to issue slices
// most-significant first (default is least-significant first).
module hamming_slicer #(
  parameter int N  = 8,
  parameter int CC = 1
) (
  input logic             clk,
  input logic             rst,
  hamming_slicer_if.slave bus
);

  localparam int M  = N / CC;
  localparam int CW = (CC > 1) ? $clog2(CC) : 1;

  typedef enum logic [1:0] {IDLE, CLR, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    g_q, g_d;
  logic [N-1:0]    e_q, e_d;
  logic [M-1:0]    g_slice_q, g_slice_d;
  logic [M-1:0]    e_slice_q, e_slice_d;
  logic            slice_valid_q, slice_valid_d;
  logic            acc_clr_q, acc_clr_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;

  // Slice selection; the order only changes which end of the word goes first.
  function automatic logic [M-1:0] slice_of(input logic [N-1:0] vec, input int idx);
    int sel;
`ifdef HAMMING_SLICER_MSB_FIRST_EN
    sel = CC - 1 - idx;
`else
    sel = idx;
`endif
    return vec[sel*M +: M];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      g_q           <= '0;
      e_q           <= '0;
      g_slice_q     <= '0;
      e_slice_q     <= '0;
      slice_valid_q <= 1'b0;
      acc_clr_q     <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      g_q           <= g_d;
      e_q           <= e_d;
      g_slice_q     <= g_slice_d;
      e_slice_q     <= e_slice_d;
      slice_valid_q <= slice_valid_d;
      acc_clr_q     <= acc_clr_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
    end
  end

  // Outputs are registered, so each branch computes what the next cycle shows.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    g_d           = g_q;
    e_d           = e_q;
    g_slice_d     = '0;
    e_slice_d     = '0;
    slice_valid_d = 1'b0;
    acc_clr_d     = 1'b0;
    last_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          g_d       = bus.g_vec;
          e_d       = bus.e_vec;
          state_d   = CLR;
          acc_clr_d = 1'b1;
        end
      end
      CLR: begin
        state_d       = SHIFT;
        cnt_d         = '0;
        g_slice_d     = slice_of(g_q, 0);
        e_slice_d     = slice_of(e_q, 0);
        slice_valid_d = 1'b1;
        last_d        = (CC == 1);
      end
      SHIFT: begin
        if (int'(cnt_q) == CC - 1) begin
          // Final slice was on the bus this cycle; return to zeroed idle.
          state_d = IDLE;
        end else begin
          cnt_d         = cnt_q + CW'(1);
          g_slice_d     = slice_of(g_q, int'(cnt_q) + 1);
          e_slice_d     = slice_of(e_q, int'(cnt_q) + 1);
          slice_valid_d = 1'b1;
          last_d        = (int'(cnt_q) + 1 == CC - 1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.g_slice     = g_slice_q;
  assign bus.e_slice     = e_slice_q;
  assign bus.slice_valid = slice_valid_q;
  assign bus.acc_clr     = acc_clr_q;
  assign bus.last        = last_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_hamming_slicer.sv
// Directed bench for hamming_slicer: one instance with CC=1 and one with
// CC=4 (N=8 both), each followed by a small accumulator modelling the
// downstream Hamming-distance consumer.
module tb_hamming_slicer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hamming_slicer_if #(.N(8), .M(8)) if1 ();
  hamming_slicer_if #(.N(8), .M(2)) if4 ();

  hamming_slicer #(.N(8), .CC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  hamming_slicer #(.N(8), .CC(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  // Downstream accumulator: acc_clr is ORed into its reset.
  int tot1, tot4;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tot1 <= 0;
      tot4 <= 0;
    end else begin
      tot1 <= if1.acc_clr ? 0 : tot1 + $countones(if1.g_slice ^ if1.e_slice);
      tot4 <= if4.acc_clr ? 0 : tot4 + $countones(if4.g_slice ^ if4.e_slice);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected slice order for g=A5, e=5A.
  logic [1:0] exp_g [4];
  logic [1:0] exp_e [4];

  initial begin
`ifdef HAMMING_SLICER_MSB_FIRST_EN
    exp_g = '{2'b10, 2'b10, 2'b01, 2'b01};
    exp_e = '{2'b01, 2'b01, 2'b10, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b10};
    exp_e = '{2'b10, 2'b10, 2'b01, 2'b01};
`endif
    rst = 1'b1;
    if1.in_valid = 1'b0; if1.g_vec = '0; if1.e_vec = '0;
    if4.in_valid = 1'b1; if4.g_vec = 8'hA5; if4.e_vec = 8'h5A;  // ignored under reset
    repeat (2) tick();

    // Reset state
    check("rst_ready4", if4.in_ready, 1);
    check("rst_busy4", if4.busy, 0);
    check("rst_sv4", if4.slice_valid, 0);
    check("rst_clr4", if4.acc_clr, 0);
    check("rst_last4", if4.last, 0);
    check("rst_gs4", if4.g_slice, 0);
    check("rst_ready1", if1.in_ready, 1);
    check("rst_gs1", if1.g_slice, 0);
    if4.in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // CC=1: g=FF e=0F
    check("c1_ready_k", if1.in_ready, 1);
    if1.in_valid = 1'b1; if1.g_vec = 8'hFF; if1.e_vec = 8'h0F;
    tick();  // cycle k+1
    if1.in_valid = 1'b0;
    check("c1_clr", if1.acc_clr, 1);
    check("c1_clr_sv", if1.slice_valid, 0);
    check("c1_clr_busy", if1.busy, 1);
    check("c1_clr_ready", if1.in_ready, 0);
    tick();  // k+2
    check("c1_gs", if1.g_slice, 8'hFF);
    check("c1_es", if1.e_slice, 8'h0F);
    check("c1_sv", if1.slice_valid, 1);
    check("c1_last", if1.last, 1);
    check("c1_noclr", if1.acc_clr, 0);
    tick();  // k+3
    check("c1_ready_back", if1.in_ready, 1);
    check("c1_idle_sv", if1.slice_valid, 0);
    check("c1_idle_gs", if1.g_slice, 0);
    check("c1_total", tot1, 4);

    // CC=4: A5/5A, with a second pair 00/FF held valid behind it
    if4.in_valid = 1'b1; if4.g_vec = 8'hA5; if4.e_vec = 8'h5A;
    tick();  // k+1
    if4.g_vec = 8'h00; if4.e_vec = 8'hFF;
    check("c4_clr", if4.acc_clr, 1);
    check("c4_clr_ready", if4.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();  // k+2+i
      check($sformatf("c4_gs%0d", i), if4.g_slice, exp_g[i]);
      check($sformatf("c4_es%0d", i), if4.e_slice, exp_e[i]);
      check($sformatf("c4_sv%0d", i), if4.slice_valid, 1);
      check($sformatf("c4_last%0d", i), if4.last, (i == 3));
      check($sformatf("c4_ready%0d", i), if4.in_ready, 0);
      check($sformatf("c4_clr%0d", i), if4.acc_clr, 0);
    end
    tick();  // k+6: second pair accepted at the coming edge
    check("c4_ready_k6", if4.in_ready, 1);
    check("c4_sv_k6", if4.slice_valid, 0);
    check("c4_total_a", tot4, 8);
    tick();  // k+7
    if4.in_valid = 1'b0;
    check("c4b_clr_k7", if4.acc_clr, 1);
    check("c4b_ready", if4.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("c4b_gs%0d", i), if4.g_slice, 2'b00);
      check($sformatf("c4b_es%0d", i), if4.e_slice, 2'b11);
      check($sformatf("c4b_last%0d", i), if4.last, (i == 3));
    end
    tick();
    check("c4b_ready_back", if4.in_ready, 1);
    check("c4b_total", tot4, 8);

    // Idle hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_sv%0d", i), if4.slice_valid, 0);
      check($sformatf("idle_gs%0d", i), if4.g_slice, 0);
      check($sformatf("idle_es%0d", i), if4.e_slice, 0);
      check($sformatf("idle_tot%0d", i), tot4, 8);
    end

    // Reset during the 2nd SHIFT cycle
    if4.in_valid = 1'b1; if4.g_vec = 8'hA5; if4.e_vec = 8'h5A;
    tick();  // k+1
    if4.in_valid = 1'b0;
    tick();  // k+2
    tick();  // k+3
    check("mid_sv", if4.slice_valid, 1);
    check("mid_gs", if4.g_slice, exp_g[1]);
    #2 rst = 1'b1;
    #1;
    check("arst_gs", if4.g_slice, 0);
    check("arst_es", if4.e_slice, 0);
    check("arst_sv", if4.slice_valid, 0);
    check("arst_last", if4.last, 0);
    check("arst_ready", if4.in_ready, 1);
    check("arst_busy", if4.busy, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_last%0d", i), if4.last, 0);
      check($sformatf("post_rst_sv%0d", i), if4.slice_valid, 0);
    end

    // New pair after reset: 03/00 -> distance 2
    if4.in_valid = 1'b1; if4.g_vec = 8'h03; if4.e_vec = 8'h00;
    tick();
    if4.in_valid = 1'b0;
    check("r_clr", if4.acc_clr, 1);
    repeat (5) tick();
    check("r_ready", if4.in_ready, 1);
    check("r_total", tot4, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
